// File: rtl/noc_pkg.sv
// Shared NoC router definitions: sizes, flit-type encodings, arbiter state.
package noc_pkg;

    localparam int NPORTS  = 5;
    localparam int FLIT_W  = 16;
    localparam int CREDITS = 5;

    // Flit type lives in the two MSBs of every flit.
    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Tail and single-flit packets share the type MSB, so one bit marks packet end.
    function automatic logic ends_packet(input logic [1:0] ftype);
        return ftype[1];
    endfunction

    // (p + k) mod NPORTS for the round-robin search and pointer advance.
    function automatic logic [2:0] port_add(input logic [2:0] p, input int k);
        return 3'((int'(p) + k) % NPORTS);
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Combinational round-robin pick among five requesters, starting at rr_ptr.
module rr_arbiter5
    import noc_pkg::*;
(
    input  logic [4:0] elig,
    input  logic [2:0] rr_ptr,
    output logic [4:0] onehot,
    output logic [2:0] index,
    output logic       any
);

    // Walk rr_ptr, rr_ptr+1, ... and keep the first eligible port.
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!any && elig[port_add(rr_ptr, k)]) begin
                any                          = 1'b1;
                index                        = port_add(rr_ptr, k);
                onehot[port_add(rr_ptr, k)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_out_port_arbiter.sv
// Output-port switch arbiter: packet-locked round-robin over the input FIFOs,
// FIFO read strobes, registered output flit and downstream credit tracking.
module noc_out_port_arbiter #(
    parameter int NPORTS  = noc_pkg::NPORTS,
    parameter int FLIT_W  = noc_pkg::FLIT_W,
    parameter int CREDITS = noc_pkg::CREDITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        fifo_emp,
    input  logic [NPORTS*FLIT_W-1:0] fifo_out,
    output logic [NPORTS-1:0]        fifo_rd,
    output logic [NPORTS-1:0]        grant,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_valid,
    input  logic                     credit_in,
    output logic [2:0]               credits
);
    import noc_pkg::*;

    arb_state_e        state;
    logic [2:0]        rr_ptr;
    logic [2:0]        owner;
    logic              inflight;

    logic [NPORTS-1:0] elig;
    logic [NPORTS-1:0] win_oh;
    logic [2:0]        win_idx;
    logic              win_any;

    logic [FLIT_W-1:0] flit_a [NPORTS];
    logic [FLIT_W-1:0] own_flit;
    logic              stop;
    logic              rd_ok;
    logic              rd_any;

    for (genvar g = 0; g < NPORTS; g++) begin : g_slice
        assign flit_a[g] = fifo_out[g*FLIT_W +: FLIT_W];
    end

    assign elig = req & ~fifo_emp;

    rr_arbiter5 u_rr (
        .elig   (elig),
        .rr_ptr (rr_ptr),
        .onehot (win_oh),
        .index  (win_idx),
        .any    (win_any)
    );

    // The flit popped last cycle is on fifo_out now; if it closes the packet,
    // the tail is already out of the FIFO and nothing more may be read.
    assign own_flit = flit_a[owner];
    assign stop     = inflight & ends_packet(own_flit[FLIT_W-1 -: 2]);
    assign rd_ok    = (state == OWN) & ~fifo_emp[owner] & (credits != 3'd0) & ~stop;
    assign fifo_rd  = rd_ok ? grant : '0;
    assign rd_any   = |fifo_rd;

    // Arbitration / ownership FSM: grant held from head until the tail is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant <= win_oh;
                        owner <= win_idx;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (stop) begin
                        grant  <= '0;
                        rr_ptr <= port_add(owner, 1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track the pop in flight and register the popped flit onto the link.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= 1'b0;
            out_valid <= 1'b0;
            out_flit  <= '0;
        end else begin
            inflight  <= rd_any;
            out_valid <= inflight;
            if (inflight) out_flit <= own_flit;
        end
    end

    // Credit counter: a read spends one slot, credit_in returns one, saturating at CREDITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= 3'(CREDITS);
        end else if (rd_any && !credit_in) begin
            credits <= credits - 3'd1;
        end else if (credit_in && !rd_any && credits != 3'(CREDITS)) begin
            credits <= credits + 3'd1;
        end
    end

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Scoreboard bench for noc_out_port_arbiter: bench-side FIFOs and downstream,
// packet-level round-robin reference model, decoupled output monitor.
module tb_noc_out_port_arbiter;
    import noc_pkg::*;

    localparam int NP = 5;
    localparam int FW = 16;
    localparam int CR = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req, fifo_emp, fifo_rd, grant;
    logic [NP*FW-1:0] fifo_out;
    logic [FW-1:0]    out_flit;
    logic             out_valid, credit_in;
    logic [2:0]       credits;

    noc_out_port_arbiter #(.NPORTS(NP), .FLIT_W(FW), .CREDITS(CR)) dut (
        .clk(clk), .rst(rst), .req(req), .fifo_emp(fifo_emp), .fifo_out(fifo_out),
        .fifo_rd(fifo_rd), .grant(grant), .out_flit(out_flit), .out_valid(out_valid),
        .credit_in(credit_in), .credits(credits)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [FW-1:0] fq [NP][$];     // bench input FIFOs
    logic [FW-1:0] mq [NP][$];     // reference copy of queued flits
    int            ml [NP][$];     // reference packet lengths
    logic [FW-1:0] exp_q [$];      // expected output flit stream
    logic [NP-1:0] exp_gq [$];     // expected grant sequence
    int            lat_q [$];      // cycle of each pop, for latency
    bit            mid [NP];
    bit            hold [NP];
    bit            gap_en, en_credit;
    int            owed, rd_count, mp, snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no expectation pending (cycle %0d)", name, cyc);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            fifo_emp[i] = (fq[i].size() == 0) || hold[i] ||
                          (gap_en && mid[i] && $urandom_range(0, 3) == 0);
            req[i]      = (fq[i].size() != 0) && !(mid[i] && $urandom_range(0, 3) == 0);
        end
    endtask

    // One clock: sample strobes mid-cycle, apply pops just after the edge,
    // then set up inputs for the next cycle.
    task automatic step(input bit cin);
        logic [NP-1:0] rd;
        logic [FW-1:0] f;
        int            rc;
        @(negedge clk);
        rd = fifo_rd;
        rc = cyc;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (rd[i] && fq[i].size() != 0) begin
                f = fq[i].pop_front();
                fifo_out[i*FW +: FW] = f;
                lat_q.push_back(rc);
                rd_count++;
                owed++;
                if (f[15:14] == FLIT_HEAD) mid[i] = 1'b1;
                else if (f[15])            mid[i] = 1'b0;
            end
        end
        drive_inputs();
        credit_in = 1'b0;
        if (cin) begin
            credit_in = 1'b1;
            if (owed > 0) owed--;
        end else if (en_credit) begin
            if (owed > 0 && $urandom_range(0, 1) == 1) begin
                credit_in = 1'b1;
                owed--;
            end else if (owed == 0 && grant == '0 && $urandom_range(0, 7) == 0) begin
                credit_in = 1'b1;
            end
        end
    endtask

    task automatic add_raw(input int p, input logic [FW-1:0] f);
        fq[p].push_back(f);
        mq[p].push_back(f);
    endtask

    task automatic add_pkt(input int p, input int len);
        logic [FW-1:0] f;
        for (int j = 0; j < len; j++) begin
            f[13:0]  = 14'($urandom);
            f[15:14] = (len == 1) ? FLIT_SINGLE : (j == 0) ? FLIT_HEAD :
                       (j == len - 1) ? FLIT_TAIL : FLIT_BODY;
            add_raw(p, f);
        end
        ml[p].push_back(len);
    endtask

    function automatic bit model_pending();
        for (int i = 0; i < NP; i++) if (ml[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Whole packets are served one at a time, searching from the port after
    // the last one served.
    task automatic model_round();
        int            w, n;
        logic [NP-1:0] g;
        while (model_pending()) begin
            w = -1;
            for (int k = 0; k < NP; k++)
                if (w < 0 && ml[(mp + k) % NP].size() != 0) w = (mp + k) % NP;
            g    = '0;
            g[w] = 1'b1;
            exp_gq.push_back(g);
            n = ml[w].pop_front();
            for (int j = 0; j < n; j++) exp_q.push_back(mq[w].pop_front());
            mp = (w + 1) % NP;
        end
        drive_inputs();
    endtask

    function automatic bit busy();
        for (int i = 0; i < NP; i++) if (fq[i].size() != 0) return 1'b1;
        return (exp_q.size() != 0) || (lat_q.size() != 0) || (grant != '0) ||
               (en_credit && owed > 0);
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (busy() && n < 1000) begin
            step(1'b0);
            n++;
        end
        tests++;
        if (n >= 1000) begin
            fails++;
            $display("FAIL %s: drain timeout after %0d cycles", name, n);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < NP; i++) begin
            fq[i].delete(); mq[i].delete(); ml[i].delete();
            mid[i] = 1'b0; hold[i] = 1'b0;
        end
        exp_q.delete(); exp_gq.delete(); lat_q.delete();
        owed = 0; mp = 0; credit_in = 1'b0;
    endtask

    // Monitor: scoreboard pops on out_valid, plus per-cycle credit and strobe rules.
    initial begin : monitor
        int            exp_cred;
        logic [NP-1:0] prev_grant;
        exp_cred   = CR;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_cred   = CR;
                prev_grant = '0;
            end else begin
                check("credits", 32'(credits), 32'(exp_cred));
                if (fifo_rd != '0)
                    check("rd_legal", 32'($countones(fifo_rd) == 1 && (fifo_rd & ~grant) == '0 &&
                          (fifo_rd & fifo_emp) == '0 && exp_cred > 0), 32'd1);
                if (grant != '0 && grant != prev_grant) begin
                    if (exp_gq.size() == 0) fail_now("grant_unexpected");
                    else check("grant_order", 32'(grant), 32'(exp_gq.pop_front()));
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) fail_now("flit_unexpected");
                    else check("out_flit", 32'(out_flit), 32'(exp_q.pop_front()));
                    if (lat_q.size() == 0) fail_now("latency_unexpected");
                    else check("latency", 32'(cyc), 32'(lat_q.pop_front() + 2));
                end
                if (fifo_rd != '0 && !credit_in)                    exp_cred--;
                else if (fifo_rd == '0 && credit_in && exp_cred < CR) exp_cred++;
                prev_grant = grant;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst = 1'b1; req = '0; fifo_emp = '1; fifo_out = '0; credit_in = 1'b0;
        gap_en = 1'b0; en_credit = 1'b1; rd_count = 0;
        flush();
        step(1'b0); step(1'b0);
        flush();
        rst = 1'b0;
        drive_inputs();

        // Single-flit packet on input 2.
        rd_count = 0;
        add_raw(2, 16'hC0AB); ml[2].push_back(1);
        model_round();
        step(1'b0);
        check("t1_grant", 32'(grant), 32'h04);
        step(1'b0);
        check("t1_credits", 32'(credits), 32'd4);
        check("t1_reads", 32'(rd_count), 32'd1);
        drain("t1");
        check("t1_total_reads", 32'(rd_count), 32'd1);

        // Pointer now sits at 3: port 3 must beat port 1.
        add_pkt(1, 1); add_pkt(3, 1);
        model_round();
        drain("t1b");

        // 3-flit packet on input 0 with input 1 waiting.
        rd_count = 0;
        add_raw(0, 16'h4001); add_raw(0, 16'h0002); add_raw(0, 16'h8003); ml[0].push_back(3);
        add_pkt(1, 2);
        model_round();
        repeat (4) step(1'b0);
        check("t2_reads", 32'(rd_count), 32'd3);
        check("t2_grant", 32'(grant), 32'h01);
        drain("t2");

        // Reset in the middle of a packet.
        add_pkt(2, 5);
        model_round();
        repeat (4) step(1'b0);
        rst = 1'b1;
        step(1'b0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_credits", 32'(credits), 32'd5);
        step(1'b0);
        flush();
        rst = 1'b0;
        drive_inputs();

        // All five request from pointer 0, port 0 queues a second packet.
        for (int i = 0; i < NP; i++) add_pkt(i, 1);
        add_pkt(0, 3);
        model_round();
        drain("t4");

        // Credit exhaustion on a 7-flit packet.
        en_credit = 1'b0;
        rd_count  = 0;
        add_pkt(3, 7);
        model_round();
        repeat (20) step(1'b0);
        check("t5_reads_at_zero", 32'(rd_count), 32'd5);
        check("t5_credits_zero", 32'(credits), 32'd0);
        step(1'b1);
        step(1'b1);
        check("t5_one_credit", 32'(credits), 32'd1);
        check("t5_no_read_yet", 32'(rd_count), 32'd5);
        step(1'b0);
        check("t5_read_plus_credit", 32'(credits), 32'd1);
        check("t5_sixth_read", 32'(rd_count), 32'd6);
        repeat (5) step(1'b0);
        check("t5_final_reads", 32'(rd_count), 32'd7);
        check("t5_final_credits", 32'(credits), 32'd0);
        en_credit = 1'b1;
        drain("t5");

        // Owner FIFO runs dry after the head; another port is waiting.
        add_pkt(1, 4);
        model_round();
        n = 0;
        while (!mid[1] && n < 20) begin
            step(1'b0);
            n++;
        end
        check("t6_head_popped", 32'(mid[1]), 32'd1);
        hold[1] = 1'b1;
        add_pkt(4, 1);
        model_round();
        snap = rd_count;
        repeat (6) step(1'b0);
        check("t6_grant_held", 32'(grant), 32'h02);
        check("t6_no_reads", 32'(rd_count), 32'(snap));
        hold[1] = 1'b0;
        drive_inputs();
        drain("t6");

        // Random packet mixes with empty gaps, req drops and random credit return.
        gap_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NP; i++) begin
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) add_pkt(i, $urandom_range(1, 5));
            end
            model_round();
            drain("rand");
        end

        check("end_flits_left", 32'(exp_q.size()), 32'd0);
        check("end_grants_left", 32'(exp_gq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
